// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake carrying {pc, instruction}.
interface instruction_fetch_unit_if;
  import ifu_pkg::*;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);
endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Shift-register FIFO of fetch entries. Slot 0 is always the head, so the
// head outputs come straight from flops with no read mux.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  localparam int CW = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  fetch_entry_t  entry_reg  [QUEUE_DEPTH];
  fetch_entry_t  entry_next [QUEUE_DEPTH];
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : gen_slot
      fetch_entry_t shift_src;
      if (gi < QUEUE_DEPTH - 1) begin : gen_shift
        assign shift_src = entry_reg[gi+1];
      end else begin : gen_last
        assign shift_src = entry_reg[gi];
      end
      // On pop everything moves down one slot and a push lands at count-1;
      // otherwise a push lands at count.
      assign entry_next[gi] = pop
        ? ((push && count_reg == CW'(gi + 1)) ? din : shift_src)
        : ((push && count_reg == CW'(gi)) ? din : entry_reg[gi]);
    end
  endgenerate

  assign count_next = flush ? '0 : (count_reg + CW'(push) - CW'(pop));

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) entry_reg[i] <= '0;
      count_reg <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) entry_reg[i] <= entry_next[i];
      count_reg <= count_next;
    end
  end

  assign head  = entry_reg[0];
  assign count = count_reg;
  assign full  = (count_reg == CW'(QUEUE_DEPTH));
  assign empty = (count_reg == '0);
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, fetch FSM and fetch queue.
// Optional IFU_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          IMEM_AW     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  instruction_fetch_unit_if.master dec,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
`endif
  output logic               misalign_err
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e  state_reg;
  logic [31:0]   pc_reg;
  logic          misalign_reg;
  logic          push;
  logic          pop;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;

  assign imem_addr = pc_reg[IMEM_AW+1:2];
  assign pop       = dec.if_valid & dec.if_ready;
  assign push      = (state_reg == FETCH) & ~redirect_valid & (~q_full | pop);
  assign q_din     = '{pc: pc_reg, instr: imem_data};

  fetch_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign dec.if_valid = ~q_empty;
  assign dec.if_instr = q_head.instr;
  assign dec.if_pc    = q_head.pc;
  assign misalign_err = misalign_reg;

  // Fetch FSM with pc and sticky misalign flag; redirect overrides pc advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      misalign_reg <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc_reg <= {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) misalign_reg <= 1'b1;
      end else if (push) begin
        pc_reg <= pc_reg + 32'(PC_STEP);
      end
      case (state_reg)
        IDLE: begin
          if (fetch_en) state_reg <= FETCH;
        end
        FETCH: begin
          if (!fetch_en) state_reg <= IDLE;
          else if (push && !pop && q_count == CW'(QUEUE_DEPTH - 1)) state_reg <= FULL;
        end
        FULL: begin
          if (!fetch_en) state_reg <= IDLE;
          else if (pop || redirect_valid) state_reg <= FETCH;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Delivered and flushed instruction counters; an entry popped during a
  // redirect counts as delivered, not flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      if (redirect_valid) perf_flushed <= perf_flushed + 32'(q_count) - 32'(pop);
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a scoreboard of expected
// pcs checked on every decode handshake, a redirect vector table, and
// hand-written sequences for backpressure, fetch_en and mid-stream reset.
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  localparam int          QD  = 4;
  localparam int          AW  = 8;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          misalign_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_flushed;
`endif
  logic [31:0]   imem [0:255];

  instruction_fetch_unit_if dec();

  always #5 clk = ~clk;
  assign imem_data = imem[imem_addr];

  instruction_fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD), .IMEM_AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .dec            (dec),
`ifdef IFU_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
`endif
    .misalign_err   (misalign_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          pop_cnt = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] target;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] mis;
  } redir_vec_t;
  redir_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return 32'hA0 + {24'b0, p[9:2]};
  endfunction

  task automatic fill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fill(RPC);
    pop_cnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_pc    = t;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    fill({t[31:2], 2'b00});
  endtask

  // Scoreboard: every accepted head must be the next expected pc.
  always @(negedge clk) begin
    if (rst_n && dec.if_valid === 1'b1 && dec.if_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", dec.if_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("POP pc=%h instr=%h expected_pc=%h", dec.if_pc, dec.if_instr, e);
        chk("pop_pc", dec.if_pc, e);
        chk("pop_instr", dec.if_instr, instr_of(e));
        pop_cnt++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'hA0 + 32'(i);
    vecs[0] = '{32'h0000_0040, 32'h10, 32'h11, 32'd0};
    vecs[1] = '{32'h0000_03FC, 32'hFF, 32'h00, 32'd0};
    vecs[2] = '{32'h0000_0080, 32'h20, 32'h21, 32'd0};
    vecs[3] = '{32'h0000_0042, 32'h10, 32'h11, 32'd1};
    vecs[4] = '{32'h0000_0100, 32'h40, 32'h41, 32'd1};
    vecs[5] = '{32'h0000_0007, 32'h01, 32'h02, 32'd1};
    dec.if_ready = 1'b0;
    fill(RPC);
    tick();
    tick();

    // Reset state.
    chk("rst_valid", 32'(dec.if_valid), 32'd0);
    chk("rst_instr", dec.if_instr, 32'd0);
    chk("rst_pc", dec.if_pc, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'(RPC[AW+1:2]));
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif

    // Startup streaming with the decoder always ready.
    fetch_en = 1'b1;
    dec.if_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dec.if_valid) break;
    end
    chk("start_valid", 32'(dec.if_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(dec.if_valid), 32'd1);
    end
    tick();
    chk("start_pops", 32'(pop_cnt >= 4), 32'd1);

    // Backpressure: queue fills to depth and pc freezes at 0x10.
    dec.if_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    @(negedge clk);
    chk("bp_imem_addr", 32'(imem_addr), 32'h4);
    chk("bp_valid", 32'(dec.if_valid), 32'd1);
    chk("bp_head_pc", dec.if_pc, 32'h0);
    chk("bp_head_instr", dec.if_instr, 32'hA0);
    tick();
    dec.if_ready = 1'b1;
    repeat (12) tick();
    chk("bp_pops", 32'(pop_cnt >= 8), 32'd1);
`ifdef IFU_PERF_CNT_EN
    chk("bp_perf_fetched", perf_fetched, 32'(pop_cnt));
`endif

    // Redirect while three entries are queued.
    dec.if_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (imem_addr == AW'(3)) break;
      tick();
    end
    chk("fill3_imem_addr", 32'(imem_addr), 32'h3);
    redirect(32'h40);
    dec.if_ready = 1'b1;
`ifdef IFU_PERF_CNT_EN
    chk("flush_perf_flushed", perf_flushed, 32'd3);
`endif
    @(negedge clk);
    chk("flush_valid", 32'(dec.if_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("redir_valid", 32'(dec.if_valid), 32'd1);
    chk("redir_pc", dec.if_pc, 32'h40);
    tick();

    // Redirect vector table: alignment, imem_addr wrap, sticky misalign.
    for (int v = 0; v < 6; v++) begin
      redirect(vecs[v].target);
      @(negedge clk);
      chk("vec_addr0", 32'(imem_addr), vecs[v].addr0);
      chk("vec_misalign", 32'(misalign_err), vecs[v].mis);
      tick();
      @(negedge clk);
      chk("vec_addr1", 32'(imem_addr), vecs[v].addr1);
      repeat (5) tick();
    end

    // fetch_en low: one last push, then pc holds and the queue drains.
    redirect(32'h200);
    fetch_en = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("halt_imem_addr", 32'(imem_addr), 32'h81);
    chk("halt_valid", 32'(dec.if_valid), 32'd0);
    tick();

    // Redirect while idle moves pc but does not fetch.
    redirect(32'h300);
    repeat (3) tick();
    @(negedge clk);
    chk("idle_redir_addr", 32'(imem_addr), 32'hC0);
    chk("idle_redir_valid", 32'(dec.if_valid), 32'd0);
    tick();
    fetch_en = 1'b1;
    repeat (8) tick();

    // Mid-stream reset with a full queue.
    dec.if_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("full_valid", 32'(dec.if_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(dec.if_valid), 32'd0);
    chk("async_rst_pc", dec.if_pc, 32'd0);
    chk("async_rst_misalign", 32'(misalign_err), 32'd0);
    chk("async_rst_imem_addr", 32'(imem_addr), 32'(RPC[AW+1:2]));
`ifdef IFU_PERF_CNT_EN
    chk("async_rst_perf_fetched", perf_fetched, 32'd0);
    chk("async_rst_perf_flushed", perf_flushed, 32'd0);
`endif
    fill(RPC);
    pop_cnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
    dec.if_ready = 1'b1;
    repeat (10) tick();
    chk("post_rst_pops", 32'(pop_cnt >= 4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that drives the word address of the combinational instruction memory and consumes its 32-bit read data.
- Holds the program counter, pushes {pc, instruction} pairs into a small fetch queue, and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the queue.
- Sits between the instruction memory (upstream) and the decoder (downstream).

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- QUEUE_DEPTH, 4, fetch queue entries; power of 2, >= 2.
- IMEM_AW, 8, instruction memory word-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  fetching permitted when high.
- redirect_valid  in  1  one-cycle redirect request from execute.
- redirect_pc  in  32  redirect target byte address.
- imem_addr  out  IMEM_AW  word address to instruction memory, equal to pc[IMEM_AW+1:2].
- imem_data  in  32  combinational read data for imem_addr.
- if_valid  out  1  queue head is valid.
- if_ready  in  1  decoder accepts head.
- if_instr  out  32  head instruction.
- if_pc  out  32  head byte address.
- misalign_err  out  1  sticky flag: a redirect target had non-zero bits [1:0].

Behaviour:
- Reset, asynchronous: pc=RESET_PC, queue empty, if_valid=0, if_instr=0, if_pc=0, misalign_err=0, state=IDLE.
- Each cycle imem_addr=pc[IMEM_AW+1:2] combinationally. imem_data is sampled in the same cycle; there is no memory wait state.
- push = (state==FETCH) & ~redirect_valid & (count<QUEUE_DEPTH | pop).
- pop = if_valid & if_ready.
- On push: write {pc, imem_data} at the tail, then pc <= pc+4.
- pc arithmetic is modulo 2^32. imem_addr wraps naturally after word 2^IMEM_AW-1 (e.g. pc 0x3FC -> 0x400 gives imem_addr 0xFF -> 0x00).
- Latency: an instruction pushed in cycle N is visible on if_valid/if_instr/if_pc in cycle N+1. Queue outputs are registered, with no combinational path from imem_data to if_*.
- Queue is FIFO. Push to full is allowed only with a simultaneous pop. Pop from empty never occurs because if_valid=0.
- if_instr and if_pc hold their values while if_valid=1 and if_ready=0.
- Redirect has the highest priority:
  - Queue count goes to 0 and if_valid=0 next cycle.
  - Any push in that cycle is discarded.
  - A simultaneous pop still completes; decoder consumed it.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - misalign_err <= 1 if redirect_pc[1:0]!=0, held until reset.
  - The target is pushed in cycle N+1 (if fetch_en) and reaches if_valid in N+2.
- FSM:
  - IDLE: no push. Go to FETCH when fetch_en=1.
  - FETCH: push when allowed. Go to FULL when count becomes QUEUE_DEPTH with no pop. Go to IDLE when fetch_en=0.
  - FULL: no push, pc frozen. Go to FETCH on pop or redirect. Go to IDLE when fetch_en=0.
- fetch_en=0 stops new pushes from the next cycle. The queue keeps draining, and pc holds.
- Redirect in IDLE updates pc and flushes; the state stays IDLE.
- rst_n asserted mid-operation: all state returns to reset values immediately. The first push after release is at RESET_PC.

Optional Feature:
- IFU_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] and perf_flushed[31:0].
  - perf_fetched increments on every pop.
  - perf_flushed increments by the queue count discarded on redirect, excluding a simultaneous pop.
  - Both counters wrap, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ifu_pkg:
  - XLEN=32
  - PC_STEP=4
  - fetch state enum {IDLE, FETCH, FULL}
  - fetch entry struct {pc[31:0], instr[31:0]}
- Sub-module fetch_queue: synchronous FIFO of fetch entries with push, pop and flush, plus count/full/empty outputs, parameterised by QUEUE_DEPTH.

Test Plan:
- Reset release with fetch_en=1, if_ready=1, memory words 0..3 = 0xA0..0xA3 -> if_valid rises at cycle 1, if_pc=0x0,0x4,0x8,0xC and if_instr=0xA0..0xA3 on consecutive cycles.
- if_ready=0 for 10 cycles -> exactly 4 entries queued, state FULL, pc=0x10 frozen. Then if_ready=1 -> pcs 0x0..0x1C delivered in order with no gaps or duplicates.
- Redirect to 0x40 while the queue holds 3 entries -> if_valid=0 next cycle, then if_pc=0x40 two cycles after the redirect; no stale pc below 0x40 appears.
- Redirect to 0x42 -> misalign_err=1 and stays 1; fetch continues from 0x40.
- Redirect to 0x3FC, IMEM_AW=8 -> imem_addr sequence 0xFF, 0x00; if_pc 0x3FC, 0x400.
- rst_n pulsed low mid-stream with the queue full -> if_valid=0 immediately; after release the first if_pc=RESET_PC. With IFU_PERF_CNT_EN, both counters read 0.
